regfile_dump_reader: RTL and testbench

- Sequential reader for the CPU register file's spare asynchronous read port (address out, data back combinationally).
- On a start pulse it sweeps every register address in order and streams (address, data) pairs out over a valid/ready handshake.
- Consumers are the debug display / UART dump path.
- Makes no writes to the register file and adds no load on the datapath read ports.

---
 rtl/regfile_dump_reader_if.sv | 37 +++
 rtl/regfile_dump_reader.sv | 143 ++++++++++++++
 tb/tb_regfile_dump_reader.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_reader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_dump_reader_if                                                   |
// | Register-file read port plus the valid/ready entry stream of the dumper. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface regfile_dump_reader_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 5
);
   logic [AW-1:0]    ra;
   logic [WIDTH-1:0] rd;
   logic             out_valid;
   logic             out_ready;
   logic [AW-1:0]    out_addr;
   logic [WIDTH-1:0] out_data;

   // master = dump reader, slave = register file + consumer side
   modport master (
      output ra,
      input  rd,
      output out_valid,
      input  out_ready,
      output out_addr,
      output out_data
   );

   modport slave (
      input  ra,
      output rd,
      input  out_valid,
      output out_ready,
      input  out_addr,
      input  out_data
   );
endinterface
`default_nettype wire

// File: rtl/regfile_dump_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_dump_reader                                                      |
// | Sweeps every register address and streams (addr, data) entries out.      |
// | Option: REGDUMP_NONZERO_ONLY_EN omits zero-valued registers.             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module regfile_dump_reader #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic                  abort_i,
   output logic                  busy_o,
   output logic                  done_o,
   regfile_dump_reader_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam logic [AW-1:0] c_LAST_ADDR = AW'(DEPTH - 1);

   state_t           state_q, state_d;
   logic [AW-1:0]    ptr_q, ptr_d;
   logic             out_valid_q, out_valid_d;
   logic [AW-1:0]    out_addr_q, out_addr_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             done_q, done_d;

   logic             w_xfer;
   logic             w_slot_free;
   logic             w_last;
   logic             w_skip;

   assign w_xfer      = out_valid_q & bus.out_ready;
   assign w_slot_free = ~out_valid_q | w_xfer;
   assign w_last      = (ptr_q == c_LAST_ADDR);

`ifdef REGDUMP_NONZERO_ONLY_EN
   assign w_skip = (bus.rd == '0);
`else
   assign w_skip = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      done_d      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // done_q marks the first IDLE cycle, where a new start is not honoured
            if (start_i && !abort_i && !done_q) begin
               state_d = S_SCAN;
               ptr_d   = '0;
            end
         end

         S_SCAN: begin
            if (abort_i) begin
               state_d     = S_IDLE;
               ptr_d       = '0;
               out_valid_d = 1'b0;
            end else if (w_slot_free) begin
               out_valid_d = 1'b0;
               if (!w_skip) begin
                  out_valid_d = 1'b1;
                  out_addr_d  = ptr_q;
                  out_data_d  = bus.rd;
               end
               if (w_last) begin
                  // a skipped final address leaves the slot empty: finish now
                  if (w_skip) begin
                     state_d = S_IDLE;
                     ptr_d   = '0;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_DRAIN;
                  end
               end else begin
                  ptr_d = ptr_q + AW'(1);
               end
            end
         end

         S_DRAIN: begin
            if (abort_i) begin
               state_d     = S_IDLE;
               ptr_d       = '0;
               out_valid_d = 1'b0;
            end else if (w_xfer) begin
               state_d     = S_IDLE;
               ptr_d       = '0;
               out_valid_d = 1'b0;
               done_d      = 1'b1;
            end
         end

         default: begin
            state_d     = S_IDLE;
            ptr_d       = '0;
            out_valid_d = 1'b0;
         end
      endcase
   end

   assign bus.ra        = ptr_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_addr  = out_addr_q;
   assign bus.out_data  = out_data_q;
   assign busy_o        = (state_q != S_IDLE);
   assign done_o        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_dump_reader                                                   |
// | Randomized self-checking bench with a queue-based stream reference model.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_regfile_dump_reader;
   localparam int WIDTH = 32;
   localparam int DEPTH = 32;
   localparam int AW    = 5;

`ifdef REGDUMP_NONZERO_ONLY_EN
   localparam int EXP_ZERO_DONE = DEPTH + 1;
   localparam int EXP_ZERO_CNT  = 0;
`else
   localparam int EXP_ZERO_DONE = DEPTH + 2;
   localparam int EXP_ZERO_CNT  = DEPTH;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic busy;
   logic done;

   logic [WIDTH-1:0] regs [DEPTH];

   regfile_dump_reader_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

   assign bus.rd = regs[bus.ra];

   regfile_dump_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start_i(start),
      .abort_i(abort),
      .busy_o (busy),
      .done_o (done),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [AW-1:0]    got_a [$];
   logic [WIDTH-1:0] got_d [$];
   int               got_c [$];
   logic [AW-1:0]    exp_a [$];
   logic [WIDTH-1:0] exp_d [$];
   int done_cnt, done_cyc, last_xfer_cyc, busy_first, busy_last, busy_cnt, stab_err;

   // Reference: the stream is every register in address order (zeros dropped if enabled)
   function automatic void build_expected();
      exp_a.delete();
      exp_d.delete();
      for (int i = 0; i < DEPTH; i++) begin
`ifdef REGDUMP_NONZERO_ONLY_EN
         if (regs[i] == '0) continue;
`endif
         exp_a.push_back(AW'(i));
         exp_d.push_back(regs[i]);
      end
   endfunction

   function automatic logic ready_of(input int mode, input int c);
      if (mode == 1) return ((c % 4) == 0) || ((c % 4) == 3);
      if (mode == 2) return ($urandom_range(0, 3) != 0);
      return 1'b1;
   endfunction

   // Start a dump at cycle 0 and record what the consumer observes (no checking here)
   task automatic collect(input int mode, input int restart_at, input bit poke_done);
      logic             stalled;
      logic [AW-1:0]    pa;
      logic [WIDTH-1:0] pd;
      got_a.delete(); got_d.delete(); got_c.delete();
      done_cnt = 0; done_cyc = -1; last_xfer_cyc = -1;
      busy_first = -1; busy_last = -1; busy_cnt = 0; stab_err = 0;
      stalled = 1'b0; pa = '0; pd = '0;
      @(posedge clk); #1;
      start = 1'b1;
      bus.out_ready = ready_of(mode, 0);
      for (int c = 1; c <= 400; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         bus.out_ready = ready_of(mode, c);
         if (stalled && (bus.out_valid !== 1'b1 || bus.out_addr !== pa || bus.out_data !== pd))
            stab_err++;
         stalled = bus.out_valid && !bus.out_ready;
         pa = bus.out_addr;
         pd = bus.out_data;
         if (bus.out_valid && bus.out_ready) begin
            got_a.push_back(bus.out_addr);
            got_d.push_back(bus.out_data);
            got_c.push_back(c);
            last_xfer_cyc = c;
         end
         if (busy) begin
            if (busy_first < 0) busy_first = c;
            busy_last = c;
            busy_cnt++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = c;
            if (poke_done) start = 1'b1;
         end
         if (restart_at >= 0 && bus.out_valid && bus.out_addr == AW'(restart_at)) start = 1'b1;
         if (done_cyc >= 0 && c >= done_cyc + 4) break;
      end
      start = 1'b0;
      bus.out_ready = 1'b1;
   endtask

   task automatic preload_ramp();
      for (int i = 0; i < DEPTH; i++) regs[i] = WIDTH'(i) * 32'h11;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_checks++; if (bus.ra !== '0) begin n_fail++; $display("FAIL reset_ra: got %0d expected 0", bus.ra); end
      n_checks++; if (bus.out_addr !== '0 || bus.out_data !== '0) begin
         n_fail++; $display("FAIL reset_outreg: got %0d/%h expected 0/0", bus.out_addr, bus.out_data); end
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_idle: got busy=%b valid=%b expected 0/0", busy, bus.out_valid); end
   endtask

   task automatic test_full_dump();
      preload_ramp();
      build_expected();
      collect(0, -1, 1'b0);
      n_checks++; if (got_a.size() !== exp_a.size()) begin
         n_fail++; $display("FAIL full_count: got %0d expected %0d", got_a.size(), exp_a.size()); end
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
         n_checks++; if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i] || got_c[i] !== int'(got_a[i]) + 2) begin
            n_fail++; $display("FAIL full_entry[%0d]: got %0d/%h@%0d expected %0d/%h@%0d",
                               i, got_a[i], got_d[i], got_c[i], exp_a[i], exp_d[i], int'(exp_a[i]) + 2); end
      end
      n_checks++; if (done_cnt !== 1 || done_cyc !== DEPTH + 2) begin
         n_fail++; $display("FAIL full_done: got cnt=%0d cyc=%0d expected 1/%0d", done_cnt, done_cyc, DEPTH + 2); end
      n_checks++; if (busy_first !== 1 || busy_last !== DEPTH + 1 || busy_cnt !== DEPTH + 1) begin
         n_fail++; $display("FAIL full_busy: got %0d..%0d n=%0d expected 1..%0d n=%0d",
                            busy_first, busy_last, busy_cnt, DEPTH + 1, DEPTH + 1); end
   endtask

   task automatic test_backpressure();
      preload_ramp();
      build_expected();
      collect(1, -1, 1'b0);
      n_checks++; if (got_a.size() !== exp_a.size()) begin
         n_fail++; $display("FAIL bp_count: got %0d expected %0d", got_a.size(), exp_a.size()); end
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
         n_checks++; if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
            n_fail++; $display("FAIL bp_entry[%0d]: got %0d/%h expected %0d/%h", i, got_a[i], got_d[i], exp_a[i], exp_d[i]); end
      end
      n_checks++; if (stab_err !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes expected 0", stab_err); end
      n_checks++; if (done_cnt !== 1 || done_cyc !== last_xfer_cyc + 1) begin
         n_fail++; $display("FAIL bp_done: got cnt=%0d cyc=%0d expected 1/%0d", done_cnt, done_cyc, last_xfer_cyc + 1); end
   endtask

   task automatic test_abort();
      int hit;
      int dn;
      preload_ramp();
      hit = 0; dn = 0;
      @(posedge clk); #1;
      start = 1'b1;
      bus.out_ready = 1'b1;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (bus.out_valid && bus.out_addr == AW'(10)) begin hit = 1; break; end
      end
      n_checks++; if (hit !== 1) begin n_fail++; $display("FAIL abort_reach: got %0d expected 1", hit); end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      n_checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL abort_stop: got valid=%b busy=%b expected 0/0", bus.out_valid, busy); end
      for (int c = 0; c < 6; c++) begin
         if (done || busy) dn++;
         @(posedge clk); #1;
      end
      n_checks++; if (dn !== 0) begin n_fail++; $display("FAIL abort_nodone: got %0d expected 0", dn); end
      build_expected();
      collect(0, -1, 1'b0);
      n_checks++; if (got_a.size() !== exp_a.size() || got_a.size() == 0 || got_a[0] !== exp_a[0] || done_cnt !== 1) begin
         n_fail++; $display("FAIL abort_redump: got n=%0d done=%0d expected n=%0d done=1", got_a.size(), done_cnt, exp_a.size()); end
   endtask

   task automatic test_restart_ignored();
      preload_ramp();
      build_expected();
      collect(0, 5, 1'b1);
      n_checks++; if (got_a.size() !== exp_a.size()) begin
         n_fail++; $display("FAIL restart_count: got %0d expected %0d", got_a.size(), exp_a.size()); end
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
         n_checks++; if (got_a[i] !== exp_a[i]) begin
            n_fail++; $display("FAIL restart_entry[%0d]: got %0d expected %0d", i, got_a[i], exp_a[i]); end
      end
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL restart_done: got %0d expected 1", done_cnt); end
      n_checks++; if (busy_last !== done_cyc - 1 || busy_cnt !== busy_last - busy_first + 1) begin
         n_fail++; $display("FAIL restart_busy: got %0d..%0d n=%0d expected end %0d", busy_first, busy_last, busy_cnt, done_cyc - 1); end
   endtask

   task automatic test_async_reset();
      int hit;
      int bad;
      preload_ramp();
      hit = 0; bad = 0;
      @(posedge clk); #1;
      start = 1'b1;
      bus.out_ready = 1'b1;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (bus.out_valid && bus.out_addr == AW'(20)) begin hit = 1; break; end
      end
      n_checks++; if (hit !== 1) begin n_fail++; $display("FAIL arst_reach: got %0d expected 1", hit); end
      #3 rst_n = 1'b0;
      #1;
      n_checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bus.ra !== '0 ||
                      bus.out_addr !== '0 || bus.out_data !== '0) begin
         n_fail++; $display("FAIL arst_outputs: got v=%b b=%b d=%b ra=%0d a=%0d dat=%h expected all 0",
                            bus.out_valid, busy, done, bus.ra, bus.out_addr, bus.out_data); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if (busy || done || bus.out_valid) bad++;
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL arst_idle: got %0d active cycles expected 0", bad); end
      build_expected();
      collect(0, -1, 1'b0);
      n_checks++; if (got_a.size() !== exp_a.size() || done_cnt !== 1) begin
         n_fail++; $display("FAIL arst_redump: got n=%0d done=%0d expected n=%0d done=1", got_a.size(), done_cnt, exp_a.size()); end
   endtask

   task automatic test_random();
      for (int it = 0; it < 3; it++) begin
         for (int i = 0; i < DEPTH; i++) regs[i] = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
         build_expected();
         collect(2, -1, 1'b0);
         n_checks++; if (got_a.size() !== exp_a.size()) begin
            n_fail++; $display("FAIL rand%0d_count: got %0d expected %0d", it, got_a.size(), exp_a.size()); end
         for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            n_checks++; if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
               n_fail++; $display("FAIL rand%0d_entry[%0d]: got %0d/%h expected %0d/%h",
                                  it, i, got_a[i], got_d[i], exp_a[i], exp_d[i]); end
         end
         n_checks++; if (stab_err !== 0 || done_cnt !== 1) begin
            n_fail++; $display("FAIL rand%0d_ctl: got stab=%0d done=%0d expected 0/1", it, stab_err, done_cnt); end
      end
   endtask

   task automatic test_sparse();
      for (int i = 0; i < DEPTH; i++) regs[i] = '0;
      regs[3]  = 32'hDEAD_BEEF;
      regs[31] = 32'h1;
      build_expected();
      collect(0, -1, 1'b0);
      n_checks++; if (got_a.size() !== exp_a.size()) begin
         n_fail++; $display("FAIL sparse_count: got %0d expected %0d", got_a.size(), exp_a.size()); end
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
         n_checks++; if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
            n_fail++; $display("FAIL sparse_entry[%0d]: got %0d/%h expected %0d/%h", i, got_a[i], got_d[i], exp_a[i], exp_d[i]); end
      end
      n_checks++; if (done_cnt !== 1 || done_cyc !== last_xfer_cyc + 1) begin
         n_fail++; $display("FAIL sparse_done: got cnt=%0d cyc=%0d expected 1/%0d", done_cnt, done_cyc, last_xfer_cyc + 1); end
      regs[3]  = '0;
      regs[31] = '0;
      collect(0, -1, 1'b0);
      n_checks++; if (got_a.size() !== EXP_ZERO_CNT) begin
         n_fail++; $display("FAIL zero_count: got %0d expected %0d", got_a.size(), EXP_ZERO_CNT); end
      n_checks++; if (done_cnt !== 1 || done_cyc !== EXP_ZERO_DONE) begin
         n_fail++; $display("FAIL zero_done: got cnt=%0d cyc=%0d expected 1/%0d", done_cnt, done_cyc, EXP_ZERO_DONE); end
   endtask

   initial begin
      bus.out_ready = 1'b1;
      test_reset();
      test_full_dump();
      test_backpressure();
      test_abort();
      test_restart_ignored();
      test_async_reset();
      test_random();
      test_sparse();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
